// File: rtl/lease_table_loader_pkg.sv
// lease_table_loader_pkg: shared constants, table selectors and loader state encoding.
`ifndef LEASE_LLT_ENTRIES
`define LEASE_LLT_ENTRIES 128
`endif

package lease_table_loader_pkg;
    localparam int LEASE_LLT_ENTRIES = `LEASE_LLT_ENTRIES;
    localparam logic [1:0] LLT_TBL_ADDR   = 2'd0;
    localparam logic [1:0] LLT_TBL_LEASE0 = 2'd1;
    localparam logic [1:0] LLT_TBL_LEASE1 = 2'd2;
    localparam logic [1:0] LLT_TBL_PROB   = 2'd3;
    localparam int CON_ADDR_DEFAULT_LEASE = 0;
    typedef enum logic [2:0] {ST_IDLE, ST_DEFAULT, ST_COUNT, ST_LOAD, ST_FILL, ST_DONE} state_t;
endpackage

// File: rtl/lease_table_loader_if.sv
// lease_table_loader_if: 32-bit valid/ready word stream feeding the loader.
interface lease_table_loader_if;
    logic [31:0] s_data;
    logic        s_valid;
    logic        s_ready;
    modport master (output s_data, s_valid, input s_ready);
    modport slave  (input s_data, s_valid, output s_ready);
endinterface

// File: rtl/lease_table_loader.sv
// lease_table_loader: streams the config word and four lease lookup tables into the
// lease policy, zero-filling unused address entries, while holding off the cache.
module lease_table_loader
    import lease_table_loader_pkg::*;
#(
    parameter int N_ENTRIES = LEASE_LLT_ENTRIES,
    localparam int BW_ENTRIES = $clog2(N_ENTRIES),
    localparam int BW_ADDR_SPACE = BW_ENTRIES + 2
) (
    input  logic                     clock_i,
    input  logic                     resetn_i,
    input  logic                     start_i,
    lease_table_loader_if.slave      s,
    output logic                     con_wren_o,
    output logic                     llt_wren_o,
    output logic [BW_ADDR_SPACE-1:0] llt_addr_o,
    output logic [31:0]              llt_data_o,
    output logic                     hold_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     error_o
);
    localparam logic [BW_ENTRIES:0] N_CNT = (BW_ENTRIES+1)'(N_ENTRIES);

    state_t                   r_state, w_next;
    logic [BW_ENTRIES:0]      r_count, w_count, r_idx, w_idx;
    logic [1:0]               r_tbl, w_tbl;
    logic                     r_con_wren, w_con_wren, r_llt_wren, w_llt_wren, r_error, w_error;
    logic [BW_ADDR_SPACE-1:0] r_addr, w_addr;
    logic [31:0]              r_data, w_data;
    logic [BW_ENTRIES:0]      w_word_cnt;
    logic                     w_bad, w_xfer, w_ready;

    assign w_ready    = (r_state == ST_DEFAULT) || (r_state == ST_COUNT) || (r_state == ST_LOAD);
    assign w_xfer     = s.s_valid & w_ready;
    assign w_word_cnt = s.s_data[BW_ENTRIES:0];
    // Any bit above the count field also rejects the word, not just an oversized count.
    assign w_bad      = (w_word_cnt > N_CNT) || (|s.s_data[31:BW_ENTRIES+1]);

    assign s.s_ready  = w_ready;
    assign con_wren_o = r_con_wren;
    assign llt_wren_o = r_llt_wren;
    assign llt_addr_o = r_addr;
    assign llt_data_o = r_data;
    assign busy_o     = r_state != ST_IDLE;
    assign hold_o     = busy_o;
    assign done_o     = r_state == ST_DONE;
    assign error_o    = r_error;

    always_comb begin
        w_next     = r_state;
        w_count    = r_count;
        w_idx      = r_idx;
        w_tbl      = r_tbl;
        w_con_wren = 1'b0;
        w_llt_wren = 1'b0;
        w_addr     = r_addr;
        w_data     = r_data;
        w_error    = r_error;
        case (r_state)
            ST_IDLE: if (start_i) begin
                w_next  = ST_DEFAULT;
                w_error = 1'b0;
            end
            ST_DEFAULT: if (w_xfer) begin
                w_con_wren = 1'b1;
                w_addr     = BW_ADDR_SPACE'(CON_ADDR_DEFAULT_LEASE);
                w_data     = s.s_data;
                w_next     = ST_COUNT;
            end
            ST_COUNT: if (w_xfer) begin
                w_count = w_word_cnt;
                w_idx   = '0;
                w_tbl   = LLT_TBL_ADDR;
                w_error = w_bad;
                w_next  = w_bad ? ST_IDLE : (w_word_cnt == '0) ? ST_FILL : ST_LOAD;
            end
            ST_LOAD: if (w_xfer) begin
                w_llt_wren = 1'b1;
                w_addr     = {r_tbl, r_idx[BW_ENTRIES-1:0]};
                w_data     = s.s_data;
                w_idx      = r_idx + 1'b1;
                if (r_idx == r_count - 1'b1) begin
                    // Leaving LOAD positions idx at count so FILL starts at the first unused entry.
                    w_idx  = (r_tbl == LLT_TBL_PROB) ? r_count : '0;
                    w_tbl  = (r_tbl == LLT_TBL_PROB) ? r_tbl : r_tbl + 1'b1;
                    w_next = (r_tbl != LLT_TBL_PROB) ? ST_LOAD : (r_count < N_CNT) ? ST_FILL : ST_DONE;
                end
            end
            ST_FILL: begin
                w_llt_wren = 1'b1;
                w_addr     = {LLT_TBL_ADDR, r_idx[BW_ENTRIES-1:0]};
                w_data     = '0;
                w_idx      = r_idx + 1'b1;
                w_next     = (r_idx == N_CNT - 1'b1) ? ST_DONE : ST_FILL;
            end
            ST_DONE: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            r_state    <= ST_IDLE;
            r_count    <= '0;
            r_idx      <= '0;
            r_tbl      <= '0;
            r_con_wren <= 1'b0;
            r_llt_wren <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_error    <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_count    <= w_count;
            r_idx      <= w_idx;
            r_tbl      <= w_tbl;
            r_con_wren <= w_con_wren;
            r_llt_wren <= w_llt_wren;
            r_addr     <= w_addr;
            r_data     <= w_data;
            r_error    <= w_error;
        end
    end
endmodule
